// File: rtl/eth_pkg.sv
// Shared definitions for the 10BASE-T receive and transmit paths.
// Contents: SFD value, CRC-32 constants (reflected form), receive state type and a
// single-bit reflected CRC-32 update helper.
package eth_pkg;

  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
  // Register value left after running the CRC over data plus a correct FCS.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    StIdle,
    StHunt,
    StData,
    StDrop,
    StEof
  } rx_state_e;

  // One reflected CRC-32 step for a single wire bit.
  function automatic logic [31:0] crc32_step(logic [31:0] crc, logic din);
    logic [31:0] shifted;
    shifted = crc >> 1;
    return (crc[0] ^ din) ? (shifted ^ CRC_POLY_R) : shifted;
  endfunction

endpackage

// File: rtl/eth_rx_if.sv
// Frame byte stream from the receive path to downstream consumers.
// Signals:
//   rx_data   received byte, LSB = first bit on the wire
//   rx_valid  one-cycle strobe, rx_data valid
//   rx_sof    with rx_valid on the first byte after SFD
//   rx_eof    one-cycle end-of-frame strobe
//   rx_crc_ok with rx_eof: FCS residue matched and no dribble bits
//   rx_err    with rx_eof: dribble bits, runt or overlength
//   rx_active receiver is hunting, receiving or dropping
// Modports: master (receiver drives), slave (consumer observes).
interface eth_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_crc_ok;
  logic       rx_err;
  logic       rx_active;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_active
  );

  modport slave (
    input rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_active
  );

endinterface

// File: rtl/manchester_dec.sv
// Manchester bit recovery for a line sampled at SAMPLES_PER_BIT samples per bit.
// Ports:
//   clk, rst    sample clock, synchronous active-high reset
//   rx_in       raw line level, asynchronous to clk
//   dec_bit     decoded bit value, valid with bit_strobe
//   bit_strobe  one-cycle strobe per qualified (mid-bit) edge
//   carrier     low once CARRIER_TIMEOUT samples pass without any line edge
module manchester_dec #(
  parameter int unsigned SAMPLES_PER_BIT = 4,
  parameter int unsigned CARRIER_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic dec_bit,
  output logic bit_strobe,
  output logic carrier
);

  localparam int unsigned HoW = $clog2(SAMPLES_PER_BIT + 1);
  localparam int unsigned CtW = $clog2(CARRIER_TIMEOUT + 1);
  // Edges closer than this to the last mid-bit edge are bit-boundary transitions.
  localparam logic [HoW-1:0] Holdoff = HoW'(SAMPLES_PER_BIT - 1);
  localparam logic [CtW-1:0] Timeout = CtW'(CARRIER_TIMEOUT);

  logic           sync1_q, sync2_q, lvl_q;
  logic [HoW-1:0] since_q;
  logic [CtW-1:0] idle_q;
  logic           bit_q, strobe_q;
  logic           edge_det, qual;

  assign edge_det = sync2_q ^ lvl_q;
  // since_q saturates at Holdoff, so equality means "at least Holdoff samples ago".
  assign qual     = edge_det && (since_q == Holdoff);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      lvl_q    <= 1'b0;
      since_q  <= '0;
      idle_q   <= '0;
      bit_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= rx_in;
      sync2_q  <= sync1_q;
      lvl_q    <= sync2_q;
      strobe_q <= qual;

      if (qual) begin
        since_q <= HoW'(1);
        bit_q   <= sync2_q;  // level after a mid-bit edge is the bit value
      end else if (since_q != Holdoff) begin
        since_q <= since_q + HoW'(1);
      end

      if (edge_det) begin
        idle_q <= '0;
      end else if (idle_q != Timeout) begin
        idle_q <= idle_q + CtW'(1);
      end
    end
  end

  assign dec_bit    = bit_q;
  assign bit_strobe = strobe_q;
  assign carrier    = (idle_q != Timeout);

endmodule

// File: rtl/eth_rx.sv
// 10BASE-T receive path: Manchester decode, preamble/SFD hunt, LSB-first byte
// assembly, FCS residue check and framing error detection.
// Ports:
//   clk, rst  40 MHz sample clock, synchronous active-high reset
//   rx_in     raw line level, asynchronous to clk
//   rx        eth_rx_if.master: byte stream, start/end strobes, status, activity
module eth_rx
  import eth_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_BIT = 4,
  parameter int unsigned CARRIER_TIMEOUT = 8,
  parameter int unsigned MIN_PRE_BITS    = 16,
  parameter int unsigned MAX_BYTES       = 1518,
  parameter int unsigned MIN_BYTES       = 64
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx_in,
  eth_rx_if.master rx
);

  localparam int unsigned BsW = $clog2(MIN_PRE_BITS + 1);
  localparam int unsigned BcW = $clog2(MAX_BYTES + 1);
  localparam logic [BsW-1:0] PreSat  = BsW'(MIN_PRE_BITS);
  localparam logic [BsW-1:0] PreLast = BsW'(MIN_PRE_BITS - 1);
  localparam logic [BcW-1:0] MaxCnt  = BcW'(MAX_BYTES);
  localparam logic [BcW-1:0] MaxLast = BcW'(MAX_BYTES - 1);
  localparam logic [BcW-1:0] MinCnt  = BcW'(MIN_BYTES);

  logic dec_bit, bit_stb, carrier;

  manchester_dec #(
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .CARRIER_TIMEOUT (CARRIER_TIMEOUT)
  ) u_dec (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .dec_bit    (dec_bit),
    .bit_strobe (bit_stb),
    .carrier    (carrier)
  );

  rx_state_e      state_q;
  logic [7:0]     hunt_sr_q, byte_sr_q, data_q;
  logic [BsW-1:0] bits_seen_q;
  logic [2:0]     bit_cnt_q;
  logic [BcW-1:0] byte_cnt_q;
  logic [31:0]    crc_q;
  logic           ovl_q, pend_q;
  logic           valid_q, sof_q, eof_q, crc_ok_q, err_q;

  logic [7:0] hunt_next, byte_next;
  logic       eof_crc_ok, eof_err;

  // Both shifters take the new bit at the MSB; after eight shifts the first bit is the LSB.
  assign hunt_next  = {dec_bit, hunt_sr_q[7:1]};
  assign byte_next  = {dec_bit, byte_sr_q[7:1]};
  assign eof_crc_ok = (crc_q == CRC_RESIDUE) && (bit_cnt_q == 3'd0);
  assign eof_err    = (bit_cnt_q != 3'd0) || (byte_cnt_q < MinCnt) || ovl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hunt_sr_q   <= '0;
      byte_sr_q   <= '0;
      data_q      <= '0;
      bits_seen_q <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= CRC_INIT;
      ovl_q       <= 1'b0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      crc_ok_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      crc_ok_q <= 1'b0;
      err_q    <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bit_stb || pend_q) begin
            state_q     <= StHunt;
            pend_q      <= 1'b0;
            hunt_sr_q   <= '0;
            bits_seen_q <= '0;
          end
        end

        StHunt: begin
          // Losing carrier here is silent: link pulses and noise never produce a frame.
          if (!carrier) begin
            state_q <= StIdle;
          end else if (bit_stb) begin
            hunt_sr_q <= hunt_next;
            if (bits_seen_q != PreSat) bits_seen_q <= bits_seen_q + BsW'(1);
            if ((bits_seen_q >= PreLast) && (hunt_next == SFD)) begin
              state_q    <= StData;
              crc_q      <= CRC_INIT;
              bit_cnt_q  <= '0;
              byte_cnt_q <= '0;
              ovl_q      <= 1'b0;
            end
          end
        end

        StData: begin
          if (!carrier) begin
            state_q  <= StEof;
            eof_q    <= 1'b1;
            crc_ok_q <= eof_crc_ok;
            err_q    <= eof_err;
          end else if (bit_stb) begin
            crc_q     <= crc32_step(crc_q, dec_bit);
            byte_sr_q <= byte_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_q  <= byte_next;
              valid_q <= 1'b1;
              sof_q   <= (byte_cnt_q == '0);
              if (byte_cnt_q != MaxCnt) byte_cnt_q <= byte_cnt_q + BcW'(1);
              if (byte_cnt_q == MaxLast) state_q <= StDrop;
            end
          end
        end

        StDrop: begin
          // Only bits past the byte limit make a frame overlength.
          if (!carrier) begin
            state_q  <= StEof;
            eof_q    <= 1'b1;
            crc_ok_q <= eof_crc_ok;
            err_q    <= eof_err;
          end else if (bit_stb) begin
            ovl_q <= 1'b1;
          end
        end

        StEof: begin
          state_q <= StIdle;
          pend_q  <= bit_stb;  // keep an edge that lands during the end strobe
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_sof    = sof_q;
  assign rx.rx_eof    = eof_q;
  assign rx.rx_crc_ok = crc_ok_q;
  assign rx.rx_err    = err_q;
  assign rx.rx_active = (state_q == StHunt) || (state_q == StData) || (state_q == StDrop);

endmodule

// File: tb/tb_eth_rx.sv
// Bench for eth_rx: builds frames with a software CRC, drives them as Manchester
// waveforms one sample per clock, and compares the received byte stream and end
// status with values derived from the frame contents.
module tb_eth_rx;

  localparam int MaxBytes = 1518;
  localparam int MinBytes = 64;
  localparam int CarrTo   = 8;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  logic rx_in;
  logic line_lvl;

  eth_rx_if rx_bus ();

  eth_rx #(
    .SAMPLES_PER_BIT (4),
    .CARRIER_TIMEOUT (CarrTo),
    .MIN_PRE_BITS    (16),
    .MAX_BYTES       (MaxBytes),
    .MIN_BYTES       (MinBytes)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .rx    (rx_bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bq_t  got_q;
  int   sof_idx[$];
  int   eof_cnt = 0;
  int   stray   = 0;
  logic eof_crc = 1'b0;
  logic eof_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_bus.rx_valid) begin
      if (rx_bus.rx_sof) sof_idx.push_back(got_q.size());
      got_q.push_back(rx_bus.rx_data);
    end
    if (rx_bus.rx_sof && !rx_bus.rx_valid) stray++;
    if (rx_bus.rx_eof) begin
      eof_cnt++;
      eof_crc = rx_bus.rx_crc_ok;
      eof_err = rx_bus.rx_err;
    end else if (rx_bus.rx_crc_ok || rx_bus.rx_err) begin
      stray++;
    end
  end

  // Reflected CRC-32 over the first nbits wire bits of d.
  function automatic logic [31:0] crc_bits(input bq_t d, input int nbits);
    logic [31:0] c;
    logic [7:0]  by;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < nbits; k++) begin
      by = d[k / 8];
      c  = (c >> 1) ^ (((c[0] ^ by[k % 8]) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
    end
    return c;
  endfunction

  function automatic bq_t make_frame(input int plen, input bit bcast);
    bq_t f;
    logic [31:0] fcs;
    for (int i = 0; i < plen; i++) begin
      f.push_back((bcast && i < 6) ? 8'hFF : 8'($urandom_range(255, 0)));
    end
    fcs = ~crc_bits(f, plen * 8);
    for (int i = 0; i < 4; i++) f.push_back(8'(fcs >> (8 * i)));
    return f;
  endfunction

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = lvl;
      @(negedge clk);
    end
  endtask

  // One bit cell of len samples: hold the previous level for half a bit, then the
  // inverse of b until the mid-bit edge, which opens the next cell.
  task automatic send_bit(input logic b, input int len);
    drive(line_lvl, 2);
    drive(~b, len - 2);
    line_lvl = b;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit jit);
    for (int i = 0; i < 8; i++) send_bit(v[i], jit ? int'($urandom_range(5, 3)) : 4);
  endtask

  task automatic run_frame(input string name, input bq_t fr, input int dribble, input bit jit,
                           input int rst_at);
    int          base, sof_base, eof_base, stray_base, nbytes, mism, total_bits, data_bits;
    int          n_got;
    bit          aborted, ovl, pending;
    logic        exp_crc_ok, exp_err;
    logic [31:0] c;

    base       = got_q.size();
    sof_base   = sof_idx.size();
    eof_base   = eof_cnt;
    stray_base = stray;
    aborted    = (rst_at >= 0);
    exp_crc_ok = 1'b0;
    exp_err    = 1'b0;
    line_lvl   = 1'b0;

    for (int i = 0; i < 7; i++) send_byte(8'h55, jit);
    send_byte(8'hD5, jit);
    for (int i = 0; i < fr.size(); i++) begin
      if (aborted && i == rst_at) break;
      send_byte(fr[i], jit);
    end

    if (aborted) begin
      drive(line_lvl, 6);
      rst      = 1'b1;
      rx_in    = 1'b0;
      line_lvl = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 30);
      nbytes = rst_at;
    end else begin
      for (int d = 0; d < dribble; d++) send_bit(1'($urandom_range(1, 0)), 4);
      drive(line_lvl, 2);
      drive(1'b0, 30);
      total_bits = fr.size() * 8 + dribble;
      ovl        = total_bits > MaxBytes * 8;
      nbytes     = ovl ? MaxBytes : fr.size();
      data_bits  = ovl ? MaxBytes * 8 : total_bits;
      pending    = !ovl && (dribble % 8 != 0);
      if (!pending) begin
        c          = crc_bits(fr, data_bits);
        exp_crc_ok = (c == 32'hDEBB_20E3);
      end
      exp_err = pending || (nbytes < MinBytes) || ovl;
    end

    n_got = got_q.size() - base;
    check_eq({name, ".nvalid"}, n_got, nbytes);
    mism = 0;
    for (int i = 0; i < nbytes && i < n_got; i++) if (got_q[base + i] != fr[i]) mism++;
    check_eq({name, ".byte_mism"}, mism, 0);
    check_eq({name, ".nsof"}, sof_idx.size() - sof_base, (nbytes > 0) ? 1 : 0);
    if (sof_idx.size() > sof_base) check_eq({name, ".sof_pos"}, sof_idx[sof_base], base);
    check_eq({name, ".neof"}, eof_cnt - eof_base, aborted ? 0 : 1);
    if (!aborted) begin
      check_eq({name, ".crc_ok"}, eof_crc, exp_crc_ok);
      check_eq({name, ".err"}, eof_err, exp_err);
    end
    check_eq({name, ".stray"}, stray - stray_base, 0);
    check_eq({name, ".active"}, rx_bus.rx_active, 1'b0);
  endtask

  initial begin
    bq_t  fa, fb, fr;
    int   base, eof_base, clr, plen, drib;
    logic seen_active;

    rst      = 1'b1;
    rx_in    = 1'b0;
    line_lvl = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst.data", rx_bus.rx_data, 8'h00);
    check_eq("rst.strobes", {rx_bus.rx_valid, rx_bus.rx_sof, rx_bus.rx_eof}, 3'b000);
    check_eq("rst.status", {rx_bus.rx_crc_ok, rx_bus.rx_err, rx_bus.rx_active}, 3'b000);
    rst = 1'b0;
    drive(1'b0, 20);

    fa = make_frame(60, 1'b1);
    run_frame("good", fa, 0, 1'b0, -1);
    check_eq("good.first", got_q[0], 8'hFF);

    fb = fa;
    fb[20] = fb[20] ^ 8'h08;
    run_frame("flip", fb, 0, 1'b0, -1);

    // Single link pulse on an idle line.
    base     = got_q.size();
    eof_base = eof_cnt;
    drive(1'b1, 4);
    rx_in       = 1'b0;
    clr         = 0;
    seen_active = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rx_bus.rx_active) seen_active = 1'b1;
      else if (seen_active) begin
        clr = k;
        break;
      end
    end
    check_eq("nlp.seen_active", seen_active, 1'b1);
    check_eq("nlp.clear_in_time", (clr > 0 && clr <= CarrTo + 4) ? 1 : 0, 1);
    drive(1'b0, 20);
    check_eq("nlp.nvalid", got_q.size() - base, 0);
    check_eq("nlp.neof", eof_cnt - eof_base, 0);

    run_frame("dribble", fa, 4, 1'b0, -1);
    run_frame("overlen", make_frame(1596, 1'b1), 0, 1'b0, -1);
    run_frame("jitter_a", fa, 0, 1'b1, -1);
    run_frame("jitter_b", make_frame(70, 1'b0), 0, 1'b1, -1);
    run_frame("abort", make_frame(60, 1'b1), 0, 1'b0, 30);
    run_frame("after_abort", fa, 0, 1'b0, -1);

    for (int r = 0; r < 3; r++) begin
      plen = $urandom_range(76, 40);
      fr   = make_frame(plen, 1'b0);
      drib = ($urandom_range(1, 0) != 0) ? 0 : int'($urandom_range(7, 1));
      if ($urandom_range(3, 0) == 0) begin
        int idx;
        idx     = $urandom_range(fr.size() - 1, 0);
        fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(7, 0));
      end
      run_frame($sformatf("rand%0d", r), fr, drib, 1'($urandom_range(1, 0)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
